// File: rtl/swap_checker.sv
// swap_checker: downstream checker for a bit-reversing register stage.
// Predicts each registered output as the bit-reversed input of the previous
// cycle, counts matches/mismatches and ends in a PASS or FAIL verdict.
// Optional macro SWAP_CHECKER_FIRST_MISMATCH_EN adds capture of the first
// mismatching output and its expected value on first_bad/first_exp.
module swap_checker #(
    parameter int unsigned      WIDTH        = 2,
    parameter logic [WIDTH-1:0] DONE_PATTERN = {WIDTH{1'b1}},
    parameter int unsigned      MAX_ERRS     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] invec,
    input  logic [WIDTH-1:0] outvec,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_cnt,
    output logic [15:0]      match_cnt,
    output logic [WIDTH-1:0] first_bad,
    output logic [WIDTH-1:0] first_exp
);

    typedef enum logic [1:0] {StIdle, StCheck, StPass, StFail} state_e;

    state_e           state_q, state_d;
    logic [7:0]       err_q, err_d;
    logic [15:0]      match_q, match_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             mismatch;

    // Bit-reverse the stage input to form next cycle's prediction.
    always_comb begin
        exp_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            exp_d[i] = invec[int'(WIDTH) - 1 - i];
        end
    end

    // A counted mismatch: only while checking and enabled.
    always_comb begin
        mismatch = (state_q == StCheck) && en && (outvec != exp_q);
    end

    // Next-state and counter updates; terminal states freeze everything.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        match_d = match_q;
        unique case (state_q)
            StIdle: begin
                // exp_q is not valid yet, so the first enabled edge only arms.
                if (en) state_d = StCheck;
            end
            StCheck: begin
                if (en) begin
                    if (outvec == exp_q) begin
                        if (match_q != 16'hFFFF) match_d = match_q + 16'd1;
                        if (outvec == DONE_PATTERN) state_d = StPass;
                    end else begin
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                        if (err_d == 8'(MAX_ERRS)) state_d = StFail;
                    end
                end
            end
            StPass, StFail: begin
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and prediction register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            err_q   <= '0;
            match_q <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            match_q <= match_d;
            // The stage runs freely, so the prediction tracks it every cycle.
            exp_q   <= exp_d;
        end
    end

    assign done      = (state_q == StPass) || (state_q == StFail);
    assign pass      = (state_q == StPass);
    assign err_cnt   = err_q;
    assign match_cnt = match_q;

`ifdef SWAP_CHECKER_FIRST_MISMATCH_EN
    logic [WIDTH-1:0] first_bad_q, first_exp_q;

    // Capture on the first mismatch after reset (err count leaving zero).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_bad_q <= '0;
            first_exp_q <= '0;
        end else if (mismatch && (err_q == 8'd0)) begin
            first_bad_q <= outvec;
            first_exp_q <= exp_q;
        end
    end

    assign first_bad = first_bad_q;
    assign first_exp = first_exp_q;
`else
    logic unused_mismatch;
    assign unused_mismatch = mismatch;
    assign first_bad       = '0;
    assign first_exp       = '0;
`endif

endmodule

// File: tb/tb_swap_checker.sv
// Self-checking bench for swap_checker: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the checker.
module tb_swap_checker;

    localparam int unsigned W        = 2;
    localparam int unsigned MAXE     = 3;
    localparam int unsigned DONE_PAT = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] invec = '0;
    logic [W-1:0] outvec = '0;
    logic         done, pass;
    logic [7:0]   err_cnt;
    logic [15:0]  match_cnt;
    logic [W-1:0] first_bad, first_exp;

    int vectors = 0;
    int errs    = 0;

    // Behavioural model state.
    bit  m_armed, m_done, m_pass;
    int  m_err, m_match, m_fb, m_fe, m_exp;

    swap_checker #(
        .WIDTH       (W),
        .DONE_PATTERN({W{1'b1}}),
        .MAX_ERRS    (MAXE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .invec    (invec),
        .outvec   (outvec),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .match_cnt(match_cnt),
        .first_bad(first_bad),
        .first_exp(first_exp)
    );

    always #5 clk = ~clk;

    function automatic int rev(input int v);
        int r = 0;
        for (int i = 0; i < int'(W); i++) r = (r * 2) + ((v >> i) & 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input int iv, input int ov);
        if (!r) begin
            m_armed = 0; m_done = 0; m_pass = 0;
            m_err = 0; m_match = 0; m_fb = 0; m_fe = 0; m_exp = 0;
            return;
        end
        if (!m_done && e) begin
            if (!m_armed) begin
                m_armed = 1;
            end else if (ov == m_exp) begin
                if (m_match < 65535) m_match++;
                if (ov == int'(DONE_PAT)) begin m_done = 1; m_pass = 1; end
            end else begin
                if (m_err == 0) begin m_fb = ov; m_fe = m_exp; end
                if (m_err < 255) m_err++;
                if (m_err == int'(MAXE)) m_done = 1;
            end
        end
        m_exp = rev(iv);
    endtask

    // Apply one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input bit r, input bit e, input int iv, input int ov);
        rst_n  = r;
        en     = e;
        invec  = W'(iv);
        outvec = W'(ov);
        model(r, e, iv, ov);
        @(posedge clk);
        #1;
        check("done", 32'(done), 32'(m_done));
        check("pass", 32'(pass), 32'(m_pass));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("match_cnt", 32'(match_cnt), 32'(m_match));
`ifdef SWAP_CHECKER_FIRST_MISMATCH_EN
        check("first_bad", 32'(first_bad), 32'(m_fb));
        check("first_exp", 32'(first_exp), 32'(m_fe));
`else
        check("first_bad", 32'(first_bad), 32'd0);
        check("first_exp", 32'(first_exp), 32'd0);
`endif
    endtask

    task automatic scen_pass();
        int iv[5] = '{0, 1, 2, 3, 0};
        int ov[5] = '{0, 0, 2, 1, 3};
        for (int i = 0; i < 5; i++) step(1, 1, iv[i], ov[i]);
    endtask

    initial begin
        int iv, ov;
        bit r, e;

        // 1. Reset with random inputs.
        step(0, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        step(0, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        check("reset_done", 32'(done), 32'd0);

        // 2. Correctly swapping stage reaches PASS.
        scen_pass();
        check("s2_match", 32'(match_cnt), 32'd4);
        check("s2_pass", 32'(pass), 32'd1);

        // 3. Non-swapping stage: outvec is the delayed invec.
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 2, 1);
        step(1, 1, 1, 2);
        step(1, 1, 2, 1);
        check("s3_err", 32'(err_cnt), 32'd3);
        check("s3_done", 32'(done), 32'd1);
        check("s3_pass", 32'(pass), 32'd0);

        // 4. en gating in CHECK.
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 2);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 3);
        step(1, 1, 0, 2);
        check("s4_match", 32'(match_cnt), 32'd2);

        // 5. Reset mid-run with err_cnt=2, then re-run the passing sequence.
        step(1, 1, 0, 3);
        step(1, 1, 0, 3);
        check("s5_err2", 32'(err_cnt), 32'd2);
        step(0, 1, 0, 3);
        check("s5_clear", 32'(err_cnt), 32'd0);
        scen_pass();

        // 6. outvec equals DONE_PATTERN while exp_q is 2'b01.
        step(0, 0, 0, 0);
        step(1, 1, 2, 0);
        step(1, 1, 0, 3);
        check("s6_done", 32'(done), 32'd0);
        check("s6_err", 32'(err_cnt), 32'd1);

        // Randomized run against the model.
        for (int n = 0; n < 600; n++) begin
            r  = !(($urandom_range(0, 99) < 3) || (m_done && $urandom_range(0, 3) == 0));
            e  = ($urandom_range(0, 9) != 0);
            iv = int'($urandom_range(0, 3));
            ov = ($urandom_range(0, 3) != 0) ? m_exp : int'($urandom_range(0, 3));
            step(r, e, iv, ov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
